ysyx_25030093_exu_ctrl: RTL and testbench

Multi-cycle execute-stage sequencer for the ALU. It accepts one decoded instruction at a time from the IDU over a valid/ready handshake. It drives alu_run and alu_single, and sequences the CSR file's synchronous read, ALU evaluation and CSR write-back for CSRRW and CSRRS. Results go to the WBU over a second valid/ready handshake, and the block counts retired operations.

---
 rtl/ysyx_25030093_exu_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_25030093_exu_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030093_exu_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_25030093_exu_ctrl
// Multi-cycle execute-stage sequencer. Accepts one decoded operation from the
// IDU, drives the ALU, sequences CSR read / ALU evaluate / CSR write-back for
// CSRRW and CSRRS, hands the result to the WBU and counts retired operations.
//
// Ports:
//   clk, reset_n (async, active low), flush (sync abort of in-flight op)
//   in_*         : IDU valid/ready request (op, operands, rd, CSR address)
//   alu_*        : ALU enable/opcode/operands out, rd and CSR results in
//   csr_*        : CSR file read strobe/address/data, write strobe/address/data
//   out_*        : WBU valid/ready response (rd, data, write enable, illegal)
//   busy         : not IDLE
//   retired      : count of completed WB handshakes (wraps)
// ----------------------------------------------------------------------------
module ysyx_25030093_exu_ctrl #(
    parameter int XLEN     = 32,
    parameter int CSR_AW   = 12,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [1:0]          in_op,
    input  logic [XLEN-1:0]     in_src1,
    input  logic [XLEN-1:0]     in_src2,
    input  logic [4:0]          in_rd,
    input  logic [CSR_AW-1:0]   in_csr_addr,
    output logic                alu_run,
    output logic [1:0]          alu_single,
    output logic [XLEN-1:0]     alu_data1,
    output logic [XLEN-1:0]     alu_data2,
    output logic [XLEN-1:0]     alu_csr_data,
    input  logic [XLEN-1:0]     alu_rd_data,
    input  logic [XLEN-1:0]     alu_csr_wdata,
    output logic                csr_ren,
    output logic [CSR_AW-1:0]   csr_raddr,
    input  logic [XLEN-1:0]     csr_rdata,
    output logic                csr_wen,
    output logic [CSR_AW-1:0]   csr_waddr,
    output logic [XLEN-1:0]     csr_wdata,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4:0]          out_rd,
    output logic [XLEN-1:0]     out_rd_data,
    output logic                out_rd_wen,
    output logic                out_illegal,
    output logic                busy,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CSRRW = 2'b01;
    localparam logic [1:0] OP_CSRRS = 2'b10;
    localparam logic [1:0] OP_ILL   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CSR_RD,
        S_EXEC,
        S_CSR_WR,
        S_WB
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            op_q;
    logic [XLEN-1:0]       src1_q, src2_q;
    logic [4:0]            rdidx_q;
    logic [CSR_AW-1:0]     caddr_q;
    logic [XLEN-1:0]       rd_q, cw_q;
    logic [RETIRE_W-1:0]   retired_q;

    logic accept;
    logic wb_fire;
    logic is_csr_op;

    // in_ready is a pure function of state; flush only gates the acceptance.
    assign accept    = (state_q == S_IDLE) && in_valid && !flush;
    // flush outranks out_ready: the result is dropped, not retired.
    assign wb_fire   = (state_q == S_WB) && out_ready && !flush;
    assign is_csr_op = (op_q == OP_CSRRW) || (op_q == OP_CSRRS);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (in_op)
                        OP_ADD:  state_d = S_EXEC;
                        OP_ILL:  state_d = S_WB;
                        default: state_d = S_CSR_RD;
                    endcase
                end
            end
            S_CSR_RD: state_d = flush ? S_IDLE : S_EXEC;
            S_EXEC: begin
                if (flush)          state_d = S_IDLE;
                else if (is_csr_op) state_d = S_CSR_WR;
                else                state_d = S_WB;
            end
            // The write strobe is already out this cycle, so a flush here
            // lets it land and only skips the WB handshake.
            S_CSR_WR: state_d = flush ? S_IDLE : S_WB;
            S_WB: begin
                if (flush || out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            rdidx_q   <= '0;
            caddr_q   <= '0;
            rd_q      <= '0;
            cw_q      <= '0;
            retired_q <= '0;
        end else begin
            if (accept) begin
                op_q    <= in_op;
                src1_q  <= in_src1;
                src2_q  <= in_src2;
                rdidx_q <= in_rd;
                caddr_q <= in_csr_addr;
            end
            if (state_q == S_EXEC && !flush) begin
                rd_q <= alu_rd_data;
                cw_q <= alu_csr_wdata;
            end
            if (wb_fire) retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    // ---------------- Moore output decode ----------------
    always_comb begin
        in_ready     = 1'b0;
        alu_run      = 1'b0;
        alu_single   = 2'b00;
        alu_csr_data = '0;
        csr_ren      = 1'b0;
        csr_wen      = 1'b0;
        out_valid    = 1'b0;
        out_rd_wen   = 1'b0;
        out_illegal  = 1'b0;
        case (state_q)
            S_IDLE:   in_ready = 1'b1;
            S_CSR_RD: csr_ren  = 1'b1;
            S_EXEC: begin
                alu_run    = 1'b1;
                alu_single = op_q;
                // CSR read data returns the cycle after csr_ren, i.e. now.
                if (is_csr_op) alu_csr_data = csr_rdata;
            end
            S_CSR_WR: csr_wen = 1'b1;
            S_WB: begin
                out_valid   = 1'b1;
                out_illegal = (op_q == OP_ILL);
                out_rd_wen  = (rdidx_q != 5'd0) && (op_q != OP_ILL);
            end
            default: ;
        endcase
    end

    assign alu_data1   = src1_q;
    assign alu_data2   = src2_q;
    assign csr_raddr   = caddr_q;
    assign csr_waddr   = caddr_q;
    assign csr_wdata   = cw_q;
    assign out_rd      = rdidx_q;
    assign out_rd_data = rd_q;
    assign busy        = (state_q != S_IDLE);
    assign retired     = retired_q;

endmodule

// File: tb/tb_ysyx_25030093_exu_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_25030093_exu_ctrl. A small ALU and CSR-file model sit around
// the DUT; directed operations push their hand-computed WB result and CSR
// write into queues, and a negedge monitor pops and compares them whenever
// the DUT presents out_valid or csr_wen.
// ----------------------------------------------------------------------------
module tb_ysyx_25030093_exu_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_src1, in_src2;
    logic [4:0]  in_rd;
    logic [11:0] in_csr_addr;
    logic        alu_run;
    logic [1:0]  alu_single;
    logic [31:0] alu_data1, alu_data2, alu_csr_data;
    logic [31:0] alu_rd_data, alu_csr_wdata;
    logic        csr_ren;
    logic [11:0] csr_raddr;
    bit   [31:0] csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_rd_data;
    logic        out_rd_wen;
    logic        out_illegal;
    logic        busy;
    logic [31:0] retired;

    ysyx_25030093_exu_ctrl #(.XLEN(32), .CSR_AW(12), .RETIRE_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_rd(in_rd), .in_csr_addr(in_csr_addr),
        .alu_run(alu_run), .alu_single(alu_single), .alu_data1(alu_data1),
        .alu_data2(alu_data2), .alu_csr_data(alu_csr_data),
        .alu_rd_data(alu_rd_data), .alu_csr_wdata(alu_csr_wdata),
        .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
        .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
        .out_rd_data(out_rd_data), .out_rd_wen(out_rd_wen), .out_illegal(out_illegal),
        .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ALU model: ADD, CSRRW (csr <- rs1), CSRRS (csr <- csr | rs1).
    assign alu_rd_data   = (alu_single == 2'b00) ? alu_data1 + alu_data2 : alu_csr_data;
    assign alu_csr_wdata = (alu_single == 2'b10) ? (alu_csr_data | alu_data1) : alu_data1;

    // CSR file model: synchronous read, synchronous write.
    bit [31:0] mem [4096];
    initial begin
        mem[12'h300] <= 32'h0000_1800;
        mem[12'h341] <= 32'h1234_5678;
        mem[12'h340] <= 32'hA5A5_A5A5;
    end
    always @(posedge clk) begin
        if (csr_ren) csr_rdata <= mem[csr_raddr];
        if (csr_wen) mem[csr_waddr] <= csr_wdata;
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          chkd;
        bit          wen;
        bit          ill;
        int          lat;
    } wb_t;
    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
    } cw_t;

    wb_t wbq[$];
    cw_t cwq[$];
    int  checks = 0;
    int  errors = 0;
    int  acc_cyc = 0;
    int  exp_ret = 0;

    // ---------------- monitor ----------------
    bit          prev_v = 1'b0;
    wb_t         e;
    cw_t         c;
    logic [4:0]  s_rd;
    logic [31:0] s_data;
    logic        s_wen, s_ill;

    always @(negedge clk) begin
        if (!reset_n) begin
            prev_v  = 1'b0;
            exp_ret = 0;
        end else begin
            if (out_valid && !prev_v) begin
                checks++;
                if (wbq.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: out_valid rose with rd=%0d data=%h, required no result", out_rd, out_rd_data);
                end else begin
                    e = wbq.pop_front();
                    if (out_rd !== e.rd || (e.chkd && out_rd_data !== e.data) || out_rd_wen !== e.wen ||
                        out_illegal !== e.ill || (cyc - acc_cyc) != e.lat || retired !== exp_ret || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL wb_result: got rd=%0d data=%h wen=%b ill=%b lat=%0d ret=%0d rdy=%b, required rd=%0d data=%h wen=%b ill=%b lat=%0d ret=%0d rdy=0",
                                 out_rd, out_rd_data, out_rd_wen, out_illegal, cyc - acc_cyc, retired, in_ready,
                                 e.rd, e.data, e.wen, e.ill, e.lat, exp_ret);
                    end
                end
                s_rd = out_rd; s_data = out_rd_data; s_wen = out_rd_wen; s_ill = out_illegal;
            end else if (out_valid) begin
                checks++;
                if (out_rd !== s_rd || out_rd_data !== s_data || out_rd_wen !== s_wen ||
                    out_illegal !== s_ill || in_ready !== 1'b0 || retired !== exp_ret) begin
                    errors++;
                    $display("FAIL wb_hold: got rd=%0d data=%h wen=%b ill=%b rdy=%b ret=%0d, required rd=%0d data=%h wen=%b ill=%b rdy=0 ret=%0d",
                             out_rd, out_rd_data, out_rd_wen, out_illegal, in_ready, retired,
                             s_rd, s_data, s_wen, s_ill, exp_ret);
                end
            end
            if (out_valid && out_ready && !flush) exp_ret++;
            prev_v = out_valid;

            if (csr_wen) begin
                checks++;
                if (cwq.size() == 0) begin
                    errors++;
                    $display("FAIL csr_unexpected: csr_wen with addr=%h data=%h, required no write", csr_waddr, csr_wdata);
                end else begin
                    c = cwq.pop_front();
                    if (csr_waddr !== c.addr || csr_wdata !== c.data) begin
                        errors++;
                        $display("FAIL csr_write: got addr=%h data=%h, required addr=%h data=%h",
                                 csr_waddr, csr_wdata, c.addr, c.data);
                    end
                end
            end
        end
    end

    // ---------------- driver helpers ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [4:0] rd, input logic [11:0] addr);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("issue_timeout_in_ready", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1; in_op = op; in_src1 = s1; in_src2 = s2; in_rd = rd; in_csr_addr = addr;
        acc_cyc = cyc;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy || wbq.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy || wbq.size() != 0) chk("wait_idle_timeout", {63'd0, busy}, 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = '0;
        in_src1 = '0; in_src2 = '0; in_rd = '0; in_csr_addr = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_strobes", {60'd0, out_valid, csr_wen, csr_ren, alu_run}, 64'd0);
        chk("rst_retired", {32'd0, retired}, 64'd0);
        chk("rst_out_rd_data", {32'd0, out_rd_data}, 64'd0);
        reset_n = 1'b1;

        // flush in IDLE blocks acceptance
        @(negedge clk);
        in_valid = 1'b1; in_op = 2'b00; flush = 1'b1;
        @(posedge clk);
        #1 chk("flush_idle_busy", {63'd0, busy}, 64'd0);
        in_valid = 1'b0; flush = 1'b0;

        // ADD: 0x10 + 0xFFFFFFF0 = 0, rd 5
        wbq.push_back('{5'd5, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2});
        issue(2'b00, 32'h0000_0010, 32'hFFFF_FFF0, 5'd5, 12'h000);
        wait_idle();
        chk("add_retired", {32'd0, retired}, 64'd1);

        // CSRRS 0x300 (0x1800) | 0x8
        cwq.push_back('{12'h300, 32'h0000_1808});
        wbq.push_back('{5'd10, 32'h0000_1800, 1'b1, 1'b1, 1'b0, 4});
        issue(2'b10, 32'h0000_0008, 32'h0, 5'd10, 12'h300);
        wait_idle();
        chk("csrrs_mem", {32'd0, mem[12'h300]}, 64'h0000_1808);

        // CSRRW rd=0: write still occurs, rd write suppressed
        cwq.push_back('{12'h341, 32'hDEAD_BEEF});
        wbq.push_back('{5'd0, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 4});
        issue(2'b01, 32'hDEAD_BEEF, 32'h0, 5'd0, 12'h341);
        wait_idle();
        chk("csrrw_retired", {32'd0, retired}, 64'd3);

        // WB back-pressure for 5 cycles
        out_ready = 1'b0;
        wbq.push_back('{5'd1, 32'h0000_0007, 1'b1, 1'b1, 1'b0, 2});
        issue(2'b00, 32'd3, 32'd4, 5'd1, 12'h000);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("hold_valid_seen", {63'd0, out_valid}, 64'd1);
        end
        repeat (5) @(negedge clk);
        chk("hold_retired", {32'd0, retired}, 64'd3);
        chk("hold_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 1'b1;
        wait_idle();
        chk("hold_done_retired", {32'd0, retired}, 64'd4);

        // flush in EXEC of a CSRRW: no write, no WB
        issue(2'b01, 32'h0000_00AA, 32'h0, 5'd4, 12'h341);
        @(negedge clk);
        chk("fexec_csr_ren", {63'd0, csr_ren}, 64'd1);
        @(negedge clk);
        chk("fexec_alu", {61'd0, alu_run, alu_single}, {61'd0, 3'b101});
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fexec_idle", {62'd0, busy, in_ready}, 64'b01);
        repeat (6) @(negedge clk);
        chk("fexec_mem", {32'd0, mem[12'h341]}, 64'hDEAD_BEEF);
        chk("fexec_retired", {32'd0, retired}, 64'd4);

        // flush in CSR_WR: write lands, WB skipped
        cwq.push_back('{12'h305, 32'h0000_0011});
        issue(2'b01, 32'h0000_0011, 32'h0, 5'd2, 12'h305);
        repeat (3) @(negedge clk);
        chk("fwr_csr_wen", {63'd0, csr_wen}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        chk("fwr_idle", {63'd0, busy}, 64'd0);
        chk("fwr_mem", {32'd0, mem[12'h305]}, 64'h0000_0011);
        repeat (6) @(negedge clk);
        chk("fwr_retired", {32'd0, retired}, 64'd4);

        // async reset in CSR_WR
        issue(2'b01, 32'h0000_0055, 32'h0, 5'd3, 12'h340);
        @(posedge clk);
        @(posedge clk);
        #1 chk("rstwr_csr_wen", {63'd0, csr_wen}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("rstwr_strobes", {60'd0, out_valid, csr_wen, csr_ren, alu_run}, 64'd0);
        chk("rstwr_idle", {62'd0, busy, in_ready}, 64'b01);
        chk("rstwr_retired", {32'd0, retired}, 64'd0);
        chk("rstwr_illegal", {63'd0, out_illegal}, 64'd0);
        @(negedge clk);
        @(posedge clk);
        #2 reset_n = 1'b1;
        chk("rstwr_mem", {32'd0, mem[12'h340]}, 64'hA5A5_A5A5);

        // illegal op
        wbq.push_back('{5'd7, 32'h0, 1'b0, 1'b0, 1'b1, 1});
        issue(2'b11, 32'd1, 32'd2, 5'd7, 12'h000);
        wait_idle();
        chk("ill_retired", {32'd0, retired}, 64'd1);

        repeat (3) @(negedge clk);
        chk("wbq_empty", 64'(wbq.size()), 64'd0);
        chk("cwq_empty", 64'(cwq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
